// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave front panel: keypad FSM encoding and
// debounce timing defaults.
package microondas_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int NUM_KEYS            = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a vector of asynchronous inputs.
module sync_2ff #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_conditioner.sv
// Debounces the 10-key keypad and emits one BCD digit strobe per accepted
// press; held keys and key changes during a hold never re-strobe.
module keypad_conditioner
    import microondas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enable,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                key_active
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_sync;
    logic [3:0]          code;
    logic                any_key;

    kp_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [3:0]          cap_q, cap_d;
    logic [3:0]          digit_q, digit_d;
    logic                dv_q, dv_d;

    sync_2ff #(.W(NUM_KEYS)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (keypad),
        .q     (key_sync)
    );

    // Ascending scan so the highest pressed index is the last write.
    always_comb begin
        code = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_sync[i]) code = 4'(i);
        end
        any_key = |key_sync;
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        digit_d = digit_q;
        dv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_key) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                    cap_d   = code;
                end
            end
            DEBOUNCE: begin
                if (!any_key || code != cap_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Accepted press still moves to HELD when the timer is busy.
                    state_d = HELD;
                    if (enable) begin
                        digit_d = cap_q;
                        dv_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!any_key) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (any_key) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= 4'd0;
            digit_q <= 4'd0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            digit_q <= digit_d;
            dv_q    <= dv_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = dv_q;
    assign key_active  = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner: press, glitch, multi-key, long hold,
// enable gating and mid-press reset scenarios.
module tb_keypad_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] keypad;
    logic       enable;
    logic [3:0] digit;
    logic       digit_valid;
    logic       key_active;

    int errors = 0;
    int checks = 0;
    int edge_n, strobes, first_edge;
    logic prev_dv = 1'b0;

    always #5 clock = ~clock;

    keypad_conditioner dut (
        .clock       (clock),
        .reset       (reset),
        .keypad      (keypad),
        .enable      (enable),
        .digit       (digit),
        .digit_valid (digit_valid),
        .key_active  (key_active)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        edge_n = 0;
        strobes = 0;
        first_edge = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edge_n++;
        if (digit_valid) begin
            strobes++;
            if (first_edge == 0) first_edge = edge_n;
            chk("dv_not_back_to_back", int'(prev_dv), 0);
        end
        prev_dv = digit_valid;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset  = 1'b1;
        keypad = 10'd0;
        enable = 1'b1;
        #1;
        chk("rst_digit", int'(digit), 0);
        chk("rst_dv", int'(digit_valid), 0);
        chk("rst_key_active", int'(key_active), 0);
        ticks(2);
        reset = 1'b0;
        ticks(2);

        // Key 4 held for 100 cycles.
        clr();
        keypad = 10'b0000010000;
        ticks(100);
        chk("k4_strobes", strobes, 1);
        chk("k4_edge", first_edge, 7);
        chk("k4_digit", int'(digit), 4);
        chk("k4_active_held", int'(key_active), 1);
        keypad = 10'd0;
        ticks(10);
        chk("k4_idle_after_release", int'(key_active), 0);

        // Two-cycle glitch on key 5.
        clr();
        keypad = 10'b0000100000;
        ticks(2);
        keypad = 10'd0;
        ticks(2);
        chk("glitch_active_e4", int'(key_active), 1);
        tick();
        chk("glitch_active_e5", int'(key_active), 0);
        ticks(5);
        chk("glitch_strobes", strobes, 0);

        // Keys 3 and 7 together: highest wins.
        clr();
        keypad = 10'b0010001000;
        ticks(20);
        chk("k37_strobes", strobes, 1);
        chk("k37_digit", int'(digit), 7);
        keypad = 10'd0;
        ticks(10);

        // Long hold of key 5 with a one-cycle dropout.
        clr();
        keypad = 10'b0000100000;
        ticks(3000);
        keypad = 10'd0;
        tick();
        keypad = 10'b0000100000;
        ticks(10);
        chk("k5_hold_strobes", strobes, 1);
        chk("k5_hold_digit", int'(digit), 5);
        keypad = 10'd0;
        ticks(10);
        chk("k5_idle", int'(key_active), 0);

        // enable=0 suppresses the strobe but the press is still consumed.
        clr();
        enable = 1'b0;
        keypad = 10'b0000000100;
        ticks(20);
        chk("k2_dis_strobes", strobes, 0);
        chk("k2_dis_digit", int'(digit), 5);
        chk("k2_dis_held", int'(key_active), 1);
        enable = 1'b1;
        ticks(5);
        chk("k2_no_late_strobe", strobes, 0);
        keypad = 10'd0;
        ticks(10);
        clr();
        keypad = 10'b1000000000;
        ticks(20);
        chk("k9_strobes", strobes, 1);
        chk("k9_digit", int'(digit), 9);
        keypad = 10'd0;
        ticks(10);

        // Reset during a key 6 press, key kept high throughout.
        clr();
        keypad = 10'b0001000000;
        ticks(4);
        reset = 1'b1;
        #1;
        chk("mid_rst_digit", int'(digit), 0);
        chk("mid_rst_dv", int'(digit_valid), 0);
        chk("mid_rst_active", int'(key_active), 0);
        ticks(2);
        chk("mid_rst_strobes", strobes, 0);
        reset = 1'b0;
        clr();
        ticks(20);
        chk("k6_post_rst_strobes", strobes, 1);
        chk("k6_post_rst_edge", first_edge, 7);
        chk("k6_post_rst_digit", int'(digit), 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
